// File: rtl/lc3_decode.sv
// LC-3 instruction decode stage: captures one instruction on decode_start and
// presents registered decoded fields one cycle later. Optional TRAP support: LC3_DECODE_TRAP_EN.
module lc3_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        decode_start,
  input  logic [15:0] instr_in,
  output logic        busy,
  output logic        decode_done,
  output logic [3:0]  opCode_out,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic        imm_mode,
  output logic [15:0] imm16,
  output logic [8:0]  offset9,
  output logic [10:0] offset11,
  output logic [2:0]  br_nzp,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        illegal,
  output logic [15:0] instr_cnt
`ifdef LC3_DECODE_TRAP_EN
  ,
  output logic        trap,
  output logic [7:0]  trapvect
`endif
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [0:0] {IDLE = 1'b0, DECODE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  dr_q, dr_d;
  logic [2:0]  sr1_q, sr1_d;
  logic [2:0]  sr2_q, sr2_d;
  logic        imm_mode_q, imm_mode_d;
  logic [15:0] imm16_q, imm16_d;
  logic [8:0]  offset9_q, offset9_d;
  logic [10:0] offset11_q, offset11_d;
  logic [2:0]  br_nzp_q, br_nzp_d;
  logic        reg_we_q, reg_we_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        illegal_q, illegal_d;
  logic [15:0] cnt_q, cnt_d;
  logic        trap_q, trap_d;
  logic [7:0]  trapvect_q, trapvect_d;

  logic [3:0]  dec_op;
  logic [2:0]  dec_dr;
  logic [2:0]  dec_sr2;
  logic        dec_imm_mode;
  logic [15:0] dec_imm16;
  logic [2:0]  dec_br_nzp;
  logic        dec_reg_we;
  logic        dec_mem_rd;
  logic        dec_mem_wr;
  logic        dec_illegal;
  logic        dec_trap;

  // Combinational decode of the captured instruction register.
  always_comb begin
    dec_op       = ir_q[15:12];
    dec_dr       = ir_q[11:9];
    dec_sr2      = ir_q[2:0];
    dec_imm_mode = 1'b0;
    dec_imm16    = 16'h0000;
    dec_br_nzp   = 3'b000;
    dec_reg_we   = 1'b0;
    dec_mem_rd   = 1'b0;
    dec_mem_wr   = 1'b0;
    dec_illegal  = 1'b0;
    dec_trap     = 1'b0;
    case (dec_op)
      OP_BR:  dec_br_nzp = ir_q[11:9];
      OP_ADD, OP_AND: begin
        dec_imm_mode = ir_q[5];
        dec_imm16    = {{11{ir_q[4]}}, ir_q[4:0]};
        dec_reg_we   = 1'b1;
      end
      OP_LD, OP_LDI: begin
        dec_reg_we = 1'b1;
        dec_mem_rd = 1'b1;
      end
      OP_LDR: begin
        dec_imm16  = {{10{ir_q[5]}}, ir_q[5:0]};
        dec_reg_we = 1'b1;
        dec_mem_rd = 1'b1;
      end
      OP_ST, OP_STI: begin
        dec_sr2    = ir_q[11:9];
        dec_mem_wr = 1'b1;
      end
      OP_STR: begin
        dec_sr2    = ir_q[11:9];
        dec_imm16  = {{10{ir_q[5]}}, ir_q[5:0]};
        dec_mem_wr = 1'b1;
      end
      OP_JSR: begin
        dec_dr     = 3'd7;
        dec_reg_we = 1'b1;
      end
      OP_NOT, OP_LEA: dec_reg_we = 1'b1;
      OP_RTI, OP_RES: dec_illegal = 1'b1;
      OP_TRAP: begin
`ifdef LC3_DECODE_TRAP_EN
        dec_trap   = 1'b1;
        dec_dr     = 3'd7;
        dec_reg_we = 1'b1;
`else
        dec_illegal = 1'b1;
`endif
      end
      default: dec_illegal = 1'b0;
    endcase
    // Illegal opcodes must never produce side effects downstream.
    if (dec_illegal) begin
      dec_reg_we = 1'b0;
      dec_mem_rd = 1'b0;
      dec_mem_wr = 1'b0;
    end else begin
      dec_reg_we = dec_reg_we;
    end
  end

  // Handshake FSM and output-register next values.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    op_d       = op_q;
    dr_d       = dr_q;
    sr1_d      = sr1_q;
    sr2_d      = sr2_q;
    imm_mode_d = imm_mode_q;
    imm16_d    = imm16_q;
    offset9_d  = offset9_q;
    offset11_d = offset11_q;
    br_nzp_d   = br_nzp_q;
    reg_we_d   = reg_we_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q;
    trap_d     = trap_q;
    trapvect_d = trapvect_q;
    case (state_q)
      IDLE: begin
        if (decode_start) begin
          state_d = DECODE;
          ir_d    = instr_in;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        op_d       = dec_op;
        dr_d       = dec_dr;
        sr1_d      = ir_q[8:6];
        sr2_d      = dec_sr2;
        imm_mode_d = dec_imm_mode;
        imm16_d    = dec_imm16;
        offset9_d  = ir_q[8:0];
        offset11_d = ir_q[10:0];
        br_nzp_d   = dec_br_nzp;
        reg_we_d   = dec_reg_we;
        mem_rd_d   = dec_mem_rd;
        mem_wr_d   = dec_mem_wr;
        illegal_d  = dec_illegal;
        cnt_d      = cnt_q + 16'd1;
        trap_d     = dec_trap;
        trapvect_d = ir_q[7:0];
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ir_q       <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_q       <= 4'h0;
      dr_q       <= 3'd0;
      sr1_q      <= 3'd0;
      sr2_q      <= 3'd0;
      imm_mode_q <= 1'b0;
      imm16_q    <= 16'h0000;
      offset9_q  <= 9'h000;
      offset11_q <= 11'h000;
      br_nzp_q   <= 3'b000;
      reg_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= 16'h0000;
      trap_q     <= 1'b0;
      trapvect_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      op_q       <= op_d;
      dr_q       <= dr_d;
      sr1_q      <= sr1_d;
      sr2_q      <= sr2_d;
      imm_mode_q <= imm_mode_d;
      imm16_q    <= imm16_d;
      offset9_q  <= offset9_d;
      offset11_q <= offset11_d;
      br_nzp_q   <= br_nzp_d;
      reg_we_q   <= reg_we_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
      trap_q     <= trap_d;
      trapvect_q <= trapvect_d;
    end
  end

  assign busy        = busy_q;
  assign decode_done = done_q;
  assign opCode_out  = op_q;
  assign dr          = dr_q;
  assign sr1         = sr1_q;
  assign sr2         = sr2_q;
  assign imm_mode    = imm_mode_q;
  assign imm16       = imm16_q;
  assign offset9     = offset9_q;
  assign offset11    = offset11_q;
  assign br_nzp      = br_nzp_q;
  assign reg_we      = reg_we_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign illegal     = illegal_q;
  assign instr_cnt   = cnt_q;
`ifdef LC3_DECODE_TRAP_EN
  assign trap        = trap_q;
  assign trapvect    = trapvect_q;
`else
  logic unused_trap_s;
  assign unused_trap_s = ^{trap_q, trapvect_q};
`endif

endmodule

// File: tb/tb_lc3_decode.sv
// Self-checking bench for lc3_decode: directed test-plan vectors plus random
// instructions against an ISA-level reference model.
module tb_lc3_decode;

  logic        clk;
  logic        rst;
  logic        decode_start;
  logic [15:0] instr_in;
  logic        busy, decode_done;
  logic [3:0]  opCode_out;
  logic [2:0]  dr, sr1, sr2, br_nzp;
  logic        imm_mode, reg_we, mem_rd, mem_wr, illegal;
  logic [15:0] imm16, instr_cnt;
  logic [8:0]  offset9;
  logic [10:0] offset11;
`ifdef LC3_DECODE_TRAP_EN
  logic        trap;
  logic [7:0]  trapvect;
  localparam int VW = 66;
`else
  localparam int VW = 57;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] model_cnt = 16'd0;

  lc3_decode dut (
    .clk(clk), .rst(rst), .decode_start(decode_start), .instr_in(instr_in),
    .busy(busy), .decode_done(decode_done), .opCode_out(opCode_out),
    .dr(dr), .sr1(sr1), .sr2(sr2), .imm_mode(imm_mode), .imm16(imm16),
    .offset9(offset9), .offset11(offset11), .br_nzp(br_nzp),
    .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .illegal(illegal),
    .instr_cnt(instr_cnt)
`ifdef LC3_DECODE_TRAP_EN
    , .trap(trap), .trapvect(trapvect)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VW-1:0] obs_vec;
  always_comb begin
    obs_vec = {opCode_out, dr, sr1, sr2, imm_mode, imm16, offset9, offset11,
               br_nzp, reg_we, mem_rd, mem_wr, illegal
`ifdef LC3_DECODE_TRAP_EN
               , trap, trapvect
`endif
              };
  end

  // ISA-level reference: what each field means for a given instruction word.
  function automatic logic [VW-1:0] model(input logic [15:0] w);
    int op;
    logic [2:0] m_dr, m_sr2, m_nzp;
    logic m_imm, m_we, m_rd, m_wr, m_ill, m_trap;
    int imm;
    op    = int'(w[15:12]);
    m_dr  = w[11:9];
    m_sr2 = (op == 3 || op == 11 || op == 7) ? w[11:9] : w[2:0];
    m_imm = (op == 1 || op == 5) ? w[5] : 1'b0;
    imm   = 0;
    if (op == 1 || op == 5) imm = (int'(w[4:0]) >= 16) ? int'(w[4:0]) - 32 : int'(w[4:0]);
    if (op == 6 || op == 7) imm = (int'(w[5:0]) >= 32) ? int'(w[5:0]) - 64 : int'(w[5:0]);
    m_nzp = (op == 0) ? w[11:9] : 3'b000;
    m_we  = (op inside {1, 5, 9, 2, 10, 6, 14, 4});
    m_rd  = (op inside {2, 10, 6});
    m_wr  = (op inside {3, 11, 7});
    m_trap = 1'b0;
    if (op == 4) m_dr = 3'd7;
`ifdef LC3_DECODE_TRAP_EN
    m_ill = (op == 8 || op == 13);
    if (op == 15) begin
      m_trap = 1'b1;
      m_dr   = 3'd7;
      m_we   = 1'b1;
    end
`else
    m_ill = (op == 8 || op == 13 || op == 15);
`endif
    return {w[15:12], m_dr, w[8:6], m_sr2, m_imm, 16'(imm), w[8:0], w[10:0],
            m_nzp, m_we, m_rd, m_wr, m_ill
`ifdef LC3_DECODE_TRAP_EN
            , m_trap, w[7:0]
`endif
           };
  endfunction

  // Issue one request; returns #1 after the edge on which outputs update.
  task automatic do_decode(input logic [15:0] w);
    @(negedge clk);
    decode_start = 1'b1;
    instr_in     = w;
    @(negedge clk);
    decode_start = 1'b0;
    instr_in     = $urandom;
    @(posedge clk);
    #1;
    model_cnt = model_cnt + 16'd1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    decode_start = 1'b0;
    instr_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({obs_vec, busy, decode_done, instr_cnt} !== '0)
      $display("FAIL reset_state: got %h/%b/%b/%h required all zero", obs_vec, busy, decode_done, instr_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 16'd0;
  endtask

  task automatic test_directed;
    @(negedge clk);
    decode_start = 1'b1;
    instr_in = 16'h2405;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, decode_done} !== 2'b10)
      $display("FAIL busy_in_decode: busy/done=%b required 10", {busy, decode_done});
    else n_pass++;
    @(negedge clk);
    decode_start = 1'b0;
    @(posedge clk);
    #1;
    model_cnt = model_cnt + 16'd1;
    n_checks++;
    if ({busy, decode_done, opCode_out, dr, offset9, mem_rd, reg_we, instr_cnt} !==
        {1'b0, 1'b1, 4'b0010, 3'd2, 9'h005, 1'b1, 1'b1, 16'd1})
      $display("FAIL ld_r2: op=%b dr=%0d off9=%h rd=%b we=%b cnt=%0d done=%b",
               opCode_out, dr, offset9, mem_rd, reg_we, instr_cnt, decode_done);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({decode_done, opCode_out, dr} !== {1'b0, 4'b0010, 3'd2})
      $display("FAIL hold_idle: done=%b op=%b dr=%0d required 0/0010/2", decode_done, opCode_out, dr);
    else n_pass++;

    do_decode(16'h12BD);
    n_checks++;
    if ({dr, sr1, imm_mode, imm16, reg_we, mem_rd} !== {3'd1, 3'd2, 1'b1, 16'hFFFD, 1'b1, 1'b0})
      $display("FAIL add_imm: dr=%0d sr1=%0d imm=%b imm16=%h we=%b rd=%b", dr, sr1, imm_mode, imm16, reg_we, mem_rd);
    else n_pass++;

    do_decode(16'h05FF);
    n_checks++;
    if ({br_nzp, offset9, reg_we} !== {3'b010, 9'h1FF, 1'b0})
      $display("FAIL brz: nzp=%b off9=%h we=%b required 010/1ff/0", br_nzp, offset9, reg_we);
    else n_pass++;

    do_decode(16'h3601);
    n_checks++;
    if ({sr2, mem_wr, br_nzp, instr_cnt} !== {3'd3, 1'b1, 3'b000, model_cnt})
      $display("FAIL st_r3: sr2=%0d wr=%b nzp=%b cnt=%0d required 3/1/000/%0d", sr2, mem_wr, br_nzp, instr_cnt, model_cnt);
    else n_pass++;
  endtask

  task automatic test_trap;
    do_decode(16'hF025);
`ifdef LC3_DECODE_TRAP_EN
    n_checks++;
    if ({trap, trapvect, dr, illegal, reg_we} !== {1'b1, 8'h25, 3'd7, 1'b0, 1'b1})
      $display("FAIL trap_en: trap=%b vec=%h dr=%0d ill=%b we=%b", trap, trapvect, dr, illegal, reg_we);
    else n_pass++;
`else
    n_checks++;
    if ({illegal, reg_we, mem_rd, mem_wr, decode_done} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL trap_illegal: ill=%b we=%b rd=%b wr=%b done=%b", illegal, reg_we, mem_rd, mem_wr, decode_done);
    else n_pass++;
`endif
    do_decode(16'h8000);
    n_checks++;
    if ({illegal, reg_we, instr_cnt} !== {1'b1, 1'b0, model_cnt})
      $display("FAIL rti_illegal: ill=%b we=%b cnt=%0d required 1/0/%0d", illegal, reg_we, instr_cnt, model_cnt);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    @(negedge clk);
    decode_start = 1'b1;
    instr_in = 16'h2405;
    @(negedge clk);
    instr_in = 16'h3601;
    @(negedge clk);
    decode_start = 1'b0;
    model_cnt = model_cnt + 16'd1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, decode_done, opCode_out, instr_cnt} !== {1'b0, 1'b0, 4'b0010, model_cnt})
      $display("FAIL ignore_start: busy=%b done=%b op=%b cnt=%0d required 0/0/0010/%0d",
               busy, decode_done, opCode_out, instr_cnt, model_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    decode_start = 1'b1;
    instr_in = 16'h12BD;
    @(negedge clk);
    decode_start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({obs_vec, busy, decode_done, instr_cnt} !== '0)
      $display("FAIL reset_abort: got %h/%b/%b/%h required all zero", obs_vec, busy, decode_done, instr_cnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 16'd0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({decode_done, instr_cnt} !== 17'd0)
      $display("FAIL abort_no_done: done=%b cnt=%0d required 0/0", decode_done, instr_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [VW-1:0] first;
    do_decode(16'h1FE0);
    first = model(16'h1FE0);
    @(negedge clk);
    decode_start = 1'b1;
    instr_in = 16'h6A7F;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, decode_done, obs_vec} !== {1'b1, 1'b0, first})
      $display("FAIL b2b_hold: busy=%b done=%b vec=%h required 1/0/%h", busy, decode_done, obs_vec, first);
    else n_pass++;
    @(negedge clk);
    decode_start = 1'b0;
    @(posedge clk);
    #1;
    model_cnt = model_cnt + 16'd1;
    n_checks++;
    if ({decode_done, obs_vec, instr_cnt} !== {1'b1, model(16'h6A7F), model_cnt})
      $display("FAIL b2b_second: done=%b vec=%h cnt=%0d required 1/%h/%0d",
               decode_done, obs_vec, instr_cnt, model(16'h6A7F), model_cnt);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [15:0] w;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom);
      if (i < 16) w[15:12] = 4'(i);
      do_decode(w);
      n_checks++;
      if ({decode_done, obs_vec, instr_cnt} !== {1'b1, model(w), model_cnt}) begin
        if (bad < 10)
          $display("FAIL random_%0d instr=%h: got %h cnt=%0d required %h cnt=%0d",
                   i, w, obs_vec, instr_cnt, model(w), model_cnt);
        bad++;
      end else n_pass++;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    model_cnt = 16'hFFFF;
    do_decode(16'hE000);
    n_checks++;
    if ({decode_done, instr_cnt} !== {1'b1, model_cnt})
      $display("FAIL cnt_wrap: done=%b cnt=%h required 1/%h", decode_done, instr_cnt, model_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_trap();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
